// File: rtl/mem_sram_port_pkg.sv
// Shared definitions for the SRAM port controller: widths, one-hot state
// encoding and byte-lane request codes.
package mem_sram_port_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int SRAM_AW = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SETUP  = 4'b0010,
    ST_STROBE = 4'b0100,
    ST_DONE   = 4'b1000
  } state_e;

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_WORD = 2'b11;

endpackage

// File: rtl/mem_sram_port.sv
// Memory port controller: turns one load/store request into one
// asynchronous SRAM cycle (setup, strobe with wait states, done) with
// byte-lane enables. Every output is a register loaded from the
// next-state view, so outputs already match the state they describe.
module mem_sram_port
  import mem_sram_port_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  memory_address,
  input  logic [DATA_W-1:0]  memory_data,
  input  logic [1:0]         memory_request,
  input  logic               memory_write,
  output logic               memory_done,
  output logic [DATA_W-1:0]  memory_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic               sram_data_oe,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [1:0]         sram_be_n
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  // Write data as placed on the pad bus: a byte store replicates its low
  // byte on both lanes so the byte enables alone select the target.
  function automatic logic [DATA_W-1:0] fmt_wdata(input logic [1:0]        lanes,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = {d[7:0], d[7:0]};
    if (lanes == LANE_WORD) r = d;
    return r;
  endfunction

  // Read result: the selected byte is right-justified and zero-extended.
  function automatic logic [DATA_W-1:0] fmt_rdata(input logic [1:0]        lanes,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    case (lanes)
      LANE_WORD: r = d;
      LANE_HI:   r = {8'h00, d[15:8]};
      LANE_LO:   r = {8'h00, d[7:0]};
      default:   r = '0;
    endcase
    return r;
  endfunction

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic [SRAM_AW-1:0]  lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [1:0]          lat_lanes;
  logic                lat_wr;

  logic                latch_en;
  logic [SRAM_AW-1:0]  op_addr;
  logic [DATA_W-1:0]   op_data;
  logic [1:0]          op_lanes;
  logic                op_wr;

  logic                done_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [SRAM_AW-1:0]  addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                data_oe_nxt;
  logic                ce_n_nxt;
  logic                we_n_nxt;
  logic                oe_n_nxt;
  logic [1:0]          be_n_nxt;

  // Byte address bit 0 never reaches the SRAM; word accesses are forced aligned.
  logic                unused_addr_lsb;
  assign unused_addr_lsb = memory_address[0];

  // Request bundle seen by the next access: live inputs while IDLE samples, latched copy otherwise.
  always_comb begin
    latch_en = (state == ST_IDLE) && (memory_request != LANE_NONE);
    op_addr  = lat_addr;
    op_data  = lat_data;
    op_lanes = lat_lanes;
    op_wr    = lat_wr;
    if (latch_en) begin
      op_addr  = memory_address[ADDR_W-1:1];
      op_data  = memory_data;
      op_lanes = memory_request;
      op_wr    = memory_write;
    end
  end

  // Hold the request bundle for the whole access so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_addr  <= op_addr;
      lat_data  <= op_data;
      lat_lanes <= op_lanes;
      lat_wr    <= op_wr;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (memory_request != LANE_NONE) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        state_nxt = ST_STROBE;
        cnt_nxt   = WS_LOAD;
      end
      ST_STROBE: begin
        if (cnt == '0) state_nxt = ST_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the state being entered; read data is captured on the last strobe cycle.
  always_comb begin
    done_nxt    = 1'b0;
    rdata_nxt   = '0;
    addr_nxt    = '0;
    wdata_nxt   = '0;
    data_oe_nxt = 1'b0;
    ce_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    oe_n_nxt    = 1'b1;
    be_n_nxt    = 2'b11;
    if (state_nxt == ST_SETUP || state_nxt == ST_STROBE) begin
      ce_n_nxt = 1'b0;
      addr_nxt = op_addr;
      be_n_nxt = ~op_lanes;
      if (op_wr) begin
        wdata_nxt   = fmt_wdata(op_lanes, op_data);
        data_oe_nxt = 1'b1;
      end
      if (state_nxt == ST_STROBE) begin
        we_n_nxt = ~op_wr;
        oe_n_nxt = op_wr;
      end
    end
    if (state_nxt == ST_DONE) begin
      done_nxt = 1'b1;
      if (!op_wr) rdata_nxt = fmt_rdata(op_lanes, sram_rdata);
    end
  end

  // State, counter and output registers; reset parks the port with all strobes inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      memory_done  <= 1'b0;
      memory_rdata <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_be_n    <= 2'b11;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      memory_done  <= done_nxt;
      memory_rdata <= rdata_nxt;
      sram_addr    <= addr_nxt;
      sram_wdata   <= wdata_nxt;
      sram_data_oe <= data_oe_nxt;
      sram_ce_n    <= ce_n_nxt;
      sram_we_n    <= we_n_nxt;
      sram_oe_n    <= oe_n_nxt;
      sram_be_n    <= be_n_nxt;
    end
  end

endmodule

// File: tb/tb_mem_sram_port.sv
// Bench for mem_sram_port: two instances (WAIT_STATES 1 and 0) driven by
// directed and random accesses, each cycle compared against a
// cycle-numbered model of the access phases.
module tb_mem_sram_port;

  logic        clk;
  logic        reset;

  logic [15:0] m_addr  [2];
  logic [15:0] m_data  [2];
  logic [1:0]  m_req   [2];
  logic        m_wr    [2];
  logic [15:0] s_rdata [2];

  logic        done_o  [2];
  logic [15:0] rdata_o [2];
  logic [14:0] saddr_o [2];
  logic [15:0] swd_o   [2];
  logic        doe_o   [2];
  logic        ce_n_o  [2];
  logic        we_n_o  [2];
  logic        oe_n_o  [2];
  logic [1:0]  be_n_o  [2];

  int n_cmp;
  int n_err;
  int cur_d;
  int cur_k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_sram_port #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset),
    .memory_address(m_addr[0]), .memory_data(m_data[0]),
    .memory_request(m_req[0]), .memory_write(m_wr[0]),
    .memory_done(done_o[0]), .memory_rdata(rdata_o[0]),
    .sram_addr(saddr_o[0]), .sram_wdata(swd_o[0]), .sram_data_oe(doe_o[0]),
    .sram_rdata(s_rdata[0]),
    .sram_ce_n(ce_n_o[0]), .sram_we_n(we_n_o[0]), .sram_oe_n(oe_n_o[0]),
    .sram_be_n(be_n_o[0])
  );

  mem_sram_port #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset),
    .memory_address(m_addr[1]), .memory_data(m_data[1]),
    .memory_request(m_req[1]), .memory_write(m_wr[1]),
    .memory_done(done_o[1]), .memory_rdata(rdata_o[1]),
    .sram_addr(saddr_o[1]), .sram_wdata(swd_o[1]), .sram_data_oe(doe_o[1]),
    .sram_rdata(s_rdata[1]),
    .sram_ce_n(ce_n_o[1]), .sram_we_n(we_n_o[1]), .sram_oe_n(oe_n_o[1]),
    .sram_be_n(be_n_o[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s (inst %0d cycle %0d): observed %0h expected %0h", tag, cur_d, cur_k, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d);
    cur_d = d;
    chk("idle_done",  32'(done_o[d]),  32'(1'b0));
    chk("idle_rdata", 32'(rdata_o[d]), 32'(16'h0000));
    chk("idle_addr",  32'(saddr_o[d]), 32'(15'h0000));
    chk("idle_wdata", 32'(swd_o[d]),   32'(16'h0000));
    chk("idle_doe",   32'(doe_o[d]),   32'(1'b0));
    chk("idle_ce_n",  32'(ce_n_o[d]),  32'(1'b1));
    chk("idle_we_n",  32'(we_n_o[d]),  32'(1'b1));
    chk("idle_oe_n",  32'(oe_n_o[d]),  32'(1'b1));
    chk("idle_be_n",  32'(be_n_o[d]),  32'(2'b11));
  endtask

  // Presents one request at the current negedge and checks every cycle up
  // to the done pulse. Cycle k=1 is SETUP, 2..2+WS strobe, 3+WS done.
  task automatic access(input int d, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] rq, input logic w, input logic [15:0] rd,
                        input bit b2b, input bit hold);
    int          ws;
    int          n;
    bit          setup, strobe, act, dn;
    logic        e_ce, e_we, e_oe, e_doe;
    logic [1:0]  e_be;
    logic [14:0] e_addr;
    logic [15:0] e_wd, e_rd, fmt_wd, fmt_rd;
    ws = ws_of(d);
    n  = 3 + ws;
    cur_d = d;
    m_addr[d]  = a;
    m_data[d]  = wd;
    m_req[d]   = rq;
    m_wr[d]    = w;
    s_rdata[d] = rd;
    fmt_wd = (rq == 2'b11) ? wd : {wd[7:0], wd[7:0]};
    if (rq == 2'b11)      fmt_rd = rd;
    else if (rq == 2'b10) fmt_rd = {8'h00, rd[15:8]};
    else                  fmt_rd = {8'h00, rd[7:0]};
    if (b2b) begin
      @(negedge clk);
      cur_k = 0;
      chk_idle(d);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cur_k  = k;
      setup  = (k == 1);
      strobe = (k >= 2) && (k <= 2 + ws);
      dn     = (k == n);
      act    = setup || strobe;
      e_ce   = !act;
      e_we   = !(strobe && w);
      e_oe   = !(strobe && !w);
      e_be   = act ? ~rq : 2'b11;
      e_addr = act ? a[15:1] : 15'h0000;
      e_doe  = act && w;
      e_wd   = (act && w) ? fmt_wd : 16'h0000;
      e_rd   = (dn && !w) ? fmt_rd : 16'h0000;
      chk("ce_n",  32'(ce_n_o[d]),  32'(e_ce));
      chk("we_n",  32'(we_n_o[d]),  32'(e_we));
      chk("oe_n",  32'(oe_n_o[d]),  32'(e_oe));
      chk("be_n",  32'(be_n_o[d]),  32'(e_be));
      chk("addr",  32'(saddr_o[d]), 32'(e_addr));
      chk("doe",   32'(doe_o[d]),   32'(e_doe));
      chk("done",  32'(done_o[d]),  32'(dn));
      chk("rdata", 32'(rdata_o[d]), 32'(e_rd));
      if (w || !act) chk("wdata", 32'(swd_o[d]), 32'(e_wd));
      if (k == 1) begin
        m_addr[d] = 16'($urandom);
        m_data[d] = 16'($urandom);
        m_wr[d]   = 1'($urandom);
        m_req[d]  = 2'($urandom_range(1, 3));
      end
      if (dn && !hold) m_req[d] = 2'b00;
    end
  endtask

  task automatic gap(input int d);
    @(negedge clk);
    cur_k = 0;
    chk_idle(d);
  endtask

  initial begin
    bit prev_hold;
    bit hold;
    n_cmp = 0;
    n_err = 0;
    cur_d = 0;
    cur_k = 0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 16'h0; m_data[i] = 16'h0; m_req[i] = 2'b00;
      m_wr[i] = 1'b0; s_rdata[i] = 16'h0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    reset = 1'b1;
    gap(0);

    // Word write at an odd address, one wait state.
    access(0, 16'h1235, 16'hBEEF, 2'b11, 1'b1, 16'h1111, 1'b0, 1'b0);
    gap(0);
    // Byte writes to the even and odd lanes.
    access(0, 16'h0010, 16'h12AB, 2'b10, 1'b1, 16'h2222, 1'b0, 1'b0);
    gap(0);
    access(0, 16'h0011, 16'h12AB, 2'b01, 1'b1, 16'h3333, 1'b0, 1'b0);
    gap(0);
    // Byte reads from both lanes.
    access(0, 16'h0011, 16'h0000, 2'b01, 1'b0, 16'h5A3C, 1'b0, 1'b0);
    gap(0);
    access(0, 16'h0010, 16'h0000, 2'b10, 1'b0, 16'h5A3C, 1'b0, 1'b0);
    gap(0);
    // Word read with no wait states.
    gap(1);
    access(1, 16'h4000, 16'h0000, 2'b11, 1'b0, 16'hC0DE, 1'b0, 1'b0);
    gap(1);
    // Request still held after done: a second access follows directly.
    access(0, 16'hFFFE, 16'hA5A5, 2'b11, 1'b1, 16'h0000, 1'b0, 1'b1);
    access(0, 16'h7FFF, 16'h0000, 2'b11, 1'b0, 16'h9876, 1'b1, 1'b0);
    gap(0);

    // Reset pulsed during the strobe of a write.
    cur_d = 0;
    cur_k = 0;
    m_addr[0] = 16'h0ACE; m_data[0] = 16'h1357; m_req[0] = 2'b11; m_wr[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pre_we_n", 32'(we_n_o[0]), 32'(1'b0));
    #2 reset = 1'b0;
    m_req[0] = 2'b00;
    #1;
    chk("rst_we_n", 32'(we_n_o[0]), 32'(1'b1));
    chk("rst_ce_n", 32'(ce_n_o[0]), 32'(1'b1));
    chk("rst_doe",  32'(doe_o[0]),  32'(1'b0));
    chk("rst_done", 32'(done_o[0]), 32'(1'b0));
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done_o[0]), 32'(1'b0));
      chk("post_rst_ce_n", 32'(ce_n_o[0]), 32'(1'b1));
    end
    access(0, 16'h0ACE, 16'h1357, 2'b11, 1'b1, 16'h0000, 1'b0, 1'b0);
    gap(0);

    // Random accesses on both instances, with random back-to-back chaining.
    for (int d = 0; d < 2; d++) begin
      prev_hold = 1'b0;
      for (int i = 0; i < 16; i++) begin
        hold = (i == 15) ? 1'b0 : 1'($urandom);
        access(d, 16'($urandom), 16'($urandom), 2'($urandom_range(1, 3)),
               1'($urandom), 16'($urandom), prev_hold, hold);
        if (!hold) gap(d);
        prev_hold = hold;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sram_port.md
# mem_sram_port

Memory port controller between the instruction execution units (store and load units) and the external 16-bit asynchronous SRAM. It consumes the request/address/data bundle those units emit and runs one SRAM cycle per request, with byte-lane enables and configurable wait states. It returns a single-cycle `memory_done` and, for reads, the read data.

## Interface

Parameters:
- `WAIT_STATES`, default 1: extra strobe cycles per access. Range 0–15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memory_address`  in  16  byte address.
- `memory_data`  in  16  write data.
- `memory_request`  in  2  byte lanes: [1] high (even) byte, [0] low (odd) byte; 0 = no request.
- `memory_write`  in  1  1 = write, 0 = read; sampled with the request.
- `memory_done`  out  1  one-cycle completion pulse.
- `memory_rdata`  out  16  read result; valid while `memory_done` = 1.
- `sram_addr`  out  15  word address.
- `sram_wdata`  out  16  data driven to SRAM.
- `sram_data_oe`  out  1  1 = top level drives `sram_wdata` onto the pad bus.
- `sram_rdata`  in  16  data from the pad bus.
- `sram_ce_n`, `sram_we_n`, `sram_oe_n`  out  1 each  active-low chip enable, write enable and output enable.
- `sram_be_n`  out  2  active-low byte enables; [1] = even/high byte.

## Operation

State machine, one-hot: IDLE → SETUP → STROBE → DONE → IDLE.

- **IDLE**
  - When `memory_request` ≠ 0, latch the address, data, lanes and `memory_write`, then go to SETUP.
  - Otherwise all SRAM controls stay inactive.
- **SETUP** (1 cycle)
  - `sram_ce_n` = 0; address and `sram_be_n` are driven.
  - For writes, `sram_data_oe` = 1 with data valid; `sram_we_n` and `sram_oe_n` stay high.
  - Load the wait counter with `WAIT_STATES`.
- **STROBE** (`WAIT_STATES` + 1 cycles)
  - Writes: `sram_we_n` = 0. Reads: `sram_oe_n` = 0.
  - When the counter = 0, capture `sram_rdata` (reads only) and go to DONE. Otherwise decrement the counter.
- **DONE** (1 cycle)
  - `memory_done` = 1 and `sram_ce_n` = 1; all strobes are deasserted.
  - `memory_rdata` holds the formatted result. Then go to IDLE.

Address and lane rules:
- `sram_addr` = `memory_address[15:1]`.
- Word access (request 2'b11): bit 0 is ignored. The access is forced aligned, with no fault.
  - Write: `sram_wdata` = `memory_data` (bits [15:8] to the even byte).
  - Read: `memory_rdata` = `sram_rdata`.
- Byte access (request 2'b10 or 2'b01):
  - Write: `memory_data[7:0]` is replicated on both lanes, and only the selected `sram_be_n` bit is 0.
  - Read: the selected byte is right-justified and zero-extended into `memory_rdata`.
- Outputs outside DONE: `memory_rdata` = 0.
- Outputs outside an active cycle: `sram_wdata` = 0 and `sram_addr` = 0.

Boundary behaviour:
- Changes to the request inputs after the IDLE sample are ignored until the next IDLE.
- Requesters clear `memory_request` on the edge where they see `memory_done`. IDLE therefore sees 0 and does not retrigger.
- If the request is still held in IDLE, a new access starts; this is legal back-to-back use.
- Reset asserted mid-access forces IDLE immediately (asynchronously), deasserts all strobes and drops `sram_data_oe`. No `memory_done` is issued.

Reset values:
- `memory_done` = 0, `memory_rdata` = 0.
- `sram_addr` = 0, `sram_wdata` = 0, `sram_data_oe` = 0.
- `sram_ce_n`, `sram_we_n`, `sram_oe_n` = 1; `sram_be_n` = 2'b11.
- State = IDLE.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: request first visible in cycle 0 → `memory_done` high in cycle 3 + `WAIT_STATES`. The next request can be sampled in cycle 4 + `WAIT_STATES`.
- Address, byte enables and write data are stable from SETUP through the last STROBE cycle.
- `sram_we_n` and `sram_oe_n` are never low in the same cycle. Each is high for at least one cycle (DONE) between accesses.

## Structure

- Shared package:
  - State encoding constants.
  - Lane constants: `LANE_NONE` = 2'b00, `LANE_LO` = 2'b01, `LANE_HI` = 2'b10, `LANE_WORD` = 2'b11.
- Single module, with no sub-module. The wait counter is a 4-bit down-counter inside the block.

## Test plan

- Word write, `WAIT_STATES` = 1, addr 0x1235, data 0xBEEF:
  - `sram_addr` = 0x091A, `sram_be_n` = 00, `sram_we_n` low for 2 cycles, `sram_wdata` = 0xBEEF.
  - `memory_done` in cycle 4.
- Byte write to 0x0010 with data 0x12AB (request 10):
  - `sram_be_n` = 01, `sram_wdata` = 0xABAB.
- Byte write to 0x0011 with data 0x12AB (request 01):
  - `sram_be_n` = 10, `sram_wdata` = 0xABAB.
- Byte read from 0x0011, `sram_rdata` = 0x5A3C → `memory_rdata` = 0x003C when done.
- Word read, `WAIT_STATES` = 0, `sram_rdata` = 0xC0DE → `memory_done` in cycle 3 with `memory_rdata` = 0xC0DE.
- Reset pulsed low during STROBE of a write:
  - `sram_we_n`, `sram_ce_n` = 1 and `sram_data_oe` = 0 without waiting for a clock edge.
  - No `memory_done`; next request completes normally.
